inst_fetch_unit: RTL and testbench

CPU-side instruction fetch stage that sits directly upstream of the instruction cache and drives its sram-like interface (cpu_req, cpu_addr, cache_addr_ok, cache_data_ok, cache_rdata). It generates sequential fetch PCs and keeps multiple requests in flight. Returned words go into an in-order instruction FIFO tagged with their PC. A redirect from the backend flushes the FIFO and discards stale in-flight responses, so decode only ever sees the correct-path stream.

---
 rtl/inst_fetch_unit.sv | 130 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage feeding decode from the I-cache
// Sequential PC generation, multiple requests in flight, PC-tagged in-order FIFO, redirect flush.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        cpu_req,
   output logic [31:0] cpu_addr,
   input  logic        cache_addr_ok,
   input  logic        cache_data_ok,
   input  logic [31:0] cache_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic          resetn_q;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   ret_pc_q, ret_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   mem_data_q [FIFO_DEPTH];
   logic [31:0]   mem_pc_q   [FIFO_DEPTH];

   logic          accept;
   logic          push;
   logic          pop;
   logic [CW:0]   occupancy;
   logic [31:0]   redirect_aligned;

   // Capacity counts both words in flight and words buffered, so a push can never overflow.
   assign occupancy        = {1'b0, inflight_q} + {1'b0, count_q};
   assign cpu_req          = resetn_q && (occupancy < (CW + 1)'(FIFO_DEPTH));
   assign cpu_addr         = fetch_pc_q;
   assign accept           = cpu_req && cache_addr_ok;
   assign push             = cache_data_ok && !redirect_valid && (discard_q == '0);
   assign pop              = inst_valid && inst_ready;
   assign redirect_aligned = redirect_pc & ~32'h3;

   assign inst_valid = (count_q != '0);
   assign inst_data  = mem_data_q[rd_ptr_q];
   assign inst_pc    = mem_pc_q[rd_ptr_q];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      ret_pc_d   = ret_pc_q;
      discard_d  = discard_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      inflight_d = inflight_q + CW'(accept) - CW'(cache_data_ok);

      if (redirect_valid) begin
         // Everything still owed by the cache, including this cycle's accept, belongs to the old path.
         fetch_pc_d = redirect_aligned;
         ret_pc_d   = redirect_aligned;
         discard_d  = inflight_d;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (cache_data_ok && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            ret_pc_d = ret_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      resetn_q <= resetn;
      if (!resetn) begin
         fetch_pc_q <= RESET_PC;
         ret_pc_q   <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         ret_pc_q   <= ret_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Entries are cleared on reset so the head reads 0 / RESET_PC until the first push.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_data_q[i] <= '0;
            mem_pc_q[i]   <= RESET_PC;
         end
      end else if (push) begin
         mem_data_q[wr_ptr_q] <= cache_rdata;
         mem_pc_q[wr_ptr_q]   <= ret_pc_q;
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!resetn)
      !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

   a_counters : assert property (@(posedge clk) disable iff (!resetn)
      (discard_q <= inflight_q) && (inflight_q <= CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized bench for inst_fetch_unit against a queue-based reference model
module tb_inst_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
   localparam int          DEPTH    = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic        cache_addr_ok;
   logic        cache_data_ok;
   logic [31:0] cache_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   always #5 clk = ~clk;

   inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .cpu_req        (cpu_req),
      .cpu_addr       (cpu_addr),
      .cache_addr_ok  (cache_addr_ok),
      .cache_data_ok  (cache_data_ok),
      .cache_rdata    (cache_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int          due;
   } req_t;

   req_t        cq[$];   // requests the cache owes, oldest first
   logic [31:0] mq[$];   // PCs decode should see, in order
   logic [31:0] m_fetch;
   bit          m_rq;
   bit          post_reset;
   int          cyc;
   int          n_checks;
   int          n_pass;

   // stimulus knobs
   bit          k_rst;
   int          k_aok, k_lat, k_dok, k_rdy, k_rdr;
   bit          k_rdr_force;
   logic [31:0] k_rdr_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
   endfunction

   function automatic bit pct(input int p);
      return $urandom_range(0, 99) < p;
   endfunction

   function automatic logic [31:0] pick_pc();
      case ($urandom_range(0, 4))
         0:       return 32'h8000_0100;
         1:       return 32'h8000_0200;
         2:       return 32'hFFFF_FFF8;
         3:       return 32'hFFFF_FFF0;
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic step();
      req_t r;
      bit   acc;
      int   lat;
      @(negedge clk);
      if (post_reset) begin
         check("rst_cpu_req", {31'b0, cpu_req}, 32'd0);
         check("rst_cpu_addr", cpu_addr, RESET_PC);
         check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
         check("rst_inst_data", inst_data, 32'd0);
         check("rst_inst_pc", inst_pc, RESET_PC);
         post_reset = 1'b0;
      end
      check("cpu_req", {31'b0, cpu_req}, {31'b0, m_rq && (cq.size() + mq.size() < DEPTH)});
      check("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
         check("inst_pc", inst_pc, mq[0]);
         check("inst_data", inst_data, mem_word(mq[0]));
      end

      if (k_rst) begin
         resetn         = 1'b0;
         cache_addr_ok  = 1'b0;
         cache_data_ok  = 1'b0;
         cache_rdata    = '0;
         redirect_valid = 1'b0;
         redirect_pc    = '0;
         inst_ready     = 1'b0;
         cq.delete();
         mq.delete();
         m_fetch    = RESET_PC;
         m_rq       = 1'b0;
         post_reset = 1'b1;
      end else begin
         resetn         = 1'b1;
         cache_addr_ok  = pct(k_aok);
         cache_data_ok  = (cq.size() != 0) && (cq[0].due <= cyc) && pct(k_dok);
         cache_rdata    = cache_data_ok ? mem_word(cq[0].addr) : $urandom;
         redirect_valid = k_rdr_force || pct(k_rdr);
         redirect_pc    = k_rdr_force ? k_rdr_pc : pick_pc();
         inst_ready     = pct(k_rdy);

         acc = cpu_req && cache_addr_ok;
         if (acc) check("cpu_addr", cpu_addr, m_fetch);
         if (inst_ready && mq.size() != 0) void'(mq.pop_front());
         if (cache_data_ok) begin
            r = cq.pop_front();
            if (!redirect_valid && !r.stale) mq.push_back(r.addr);
         end
         if (acc) begin
            lat = (k_lat == 0) ? int'($urandom_range(1, 4)) : k_lat;
            cq.push_back('{addr: cpu_addr, stale: 1'b0, due: cyc + lat});
         end
         if (redirect_valid) begin
            foreach (cq[i]) cq[i].stale = 1'b1;
            mq.delete();
            m_fetch = redirect_pc & ~32'h3;
         end else if (acc) begin
            m_fetch = m_fetch + 32'd4;
         end
         m_rq = 1'b1;
      end
      k_rdr_force = 1'b0;
      @(posedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      k_rdr_force = 1'b1;
      k_rdr_pc    = pc;
      step();
   endtask

   initial begin
      n_checks = 0; n_pass = 0; cyc = 0;
      m_rq = 1'b0; m_fetch = RESET_PC; post_reset = 1'b0;
      k_rdr_force = 1'b0; k_rdr_pc = '0;
      resetn = 1'b0; cache_addr_ok = 1'b0; cache_data_ok = 1'b0; cache_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

      // reset, then steady stream with fixed 3-cycle latency
      k_rst = 1'b1; run(3);
      k_rst = 1'b0; k_aok = 100; k_lat = 3; k_dok = 100; k_rdy = 100; k_rdr = 0;
      run(30);

      // decode stalled, single-cycle release, stalled again
      k_rdy = 0;   run(20);
      k_rdy = 100; run(1);
      k_rdy = 0;   run(6);
      k_rdy = 100; run(10);

      // redirects with requests in flight, then back-to-back and wrap
      redirect_to(32'h8000_0100); run(12);
      redirect_to(32'h8000_0104); step(); redirect_to(32'h8000_0200); run(12);
      redirect_to(32'hFFFF_FFF8); run(15);
      redirect_to(32'h1234_5677); run(8);

      // reset mid-stream
      k_rst = 1'b1; run(1);
      k_rst = 1'b0; run(15);

      // random traffic with occasional redirects and resets
      k_aok = 70; k_lat = 0; k_dok = 70; k_rdy = 70; k_rdr = 5;
      for (int blk = 0; blk < 6; blk++) begin
         run(600);
         k_rst = 1'b1; run($urandom_range(1, 2));
         k_rst = 1'b0;
      end
      k_rdr = 0; k_rdy = 40; run(400);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
